// File: rtl/physical_iob_delay_ctrl_pkg.sv
// Shared encodings for the IDELAY tap controller.
// Holds grant and FSM state encodings and the default tap width.
// Imported by the arbiter and the controller top.
package physical_iob_delay_ctrl_pkg;

  localparam int TAB_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_CAL  = 2'd1,
    GRANT_MON  = 2'd2,
    GRANT_MAN  = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/physical_iob_delay_arbiter.sv
// Fixed-priority tap-update request selector: man (when enabled) > cal > mon.
// Latency: combinational, no state.
// Backpressure: while man mode is enabled, cal and mon are never selected and stay pending.
module physical_iob_delay_arbiter
  import physical_iob_delay_ctrl_pkg::*;
(
  input  logic   cal_req,
  input  logic   mon_req,
  input  logic   man_enable,
  input  logic   man_req,
  output grant_t grant_sel
);

  // Pick the highest-priority active requester; man mode blocks the others outright.
  always_comb begin
    grant_sel = GRANT_NONE;
    if (man_enable) begin
      if (man_req) grant_sel = GRANT_MAN;
    end else if (cal_req) begin
      grant_sel = GRANT_CAL;
    end else if (mon_req) begin
      grant_sel = GRANT_MON;
    end
  end

endmodule

// File: rtl/physical_iob_delay_ctrl.sv
// Serialises IDELAY tap updates for the master and monitor ISERDES paths.
// Latency: req->ack 2+SETTLE_CYCLES cycles, 1 cycle when the requested taps already match.
// Backpressure: level requests held until the one-cycle ack; losers stay pending.
// Optional: DELAY_CTRL_STEP_LIMIT_EN limits monitor-requested moves to one tap per transfer.
module physical_iob_delay_ctrl
  import physical_iob_delay_ctrl_pkg::*;
#(
  parameter int TAB_WIDTH        = TAB_WIDTH_DEF,
  parameter int SETTLE_CYCLES    = 8,
  parameter int SETTLE_CNT_WIDTH = 4
) (
  input  logic                 i_clk_200,
  input  logic                 local_clk_200_rst,
  input  logic                 i_cal_req,
  input  logic [TAB_WIDTH-1:0] i_cal_master_tabs,
  output logic                 o_cal_ack,
  input  logic                 i_mon_req,
  input  logic [TAB_WIDTH-1:0] i_mon_master_tabs,
  input  logic [TAB_WIDTH-1:0] i_mon_monitor_tabs,
  output logic                 o_mon_ack,
  input  logic                 i_man_enable,
  input  logic                 i_man_req,
  input  logic [TAB_WIDTH-1:0] i_man_tabs,
  output logic                 o_man_ack,
  output logic [TAB_WIDTH-1:0] o_master_delay,
  output logic [TAB_WIDTH-1:0] o_monitor_delay,
  output logic                 o_delay_ld,
  output logic                 o_busy,
  output logic [1:0]           o_grant,
  output logic                 o_update_wr
);

  localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_LAST =
    SETTLE_CNT_WIDTH'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  state_t                      state, state_nxt;
  grant_t                      grant_q, grant_nxt, win;
  logic [SETTLE_CNT_WIDTH-1:0] settle_cnt;
  logic [TAB_WIDTH-1:0]        mon_master_new, mon_monitor_new;
  logic [TAB_WIDTH-1:0]        win_master, win_monitor;
  logic                        win_sets_monitor, win_equal, do_load;

  physical_iob_delay_arbiter u_arb (
    .cal_req    (i_cal_req),
    .mon_req    (i_mon_req),
    .man_enable (i_man_enable),
    .man_req    (i_man_req),
    .grant_sel  (win)
  );

`ifdef DELAY_CTRL_STEP_LIMIT_EN
  // Monitor moves each tap by at most one step toward its target per transfer.
  always_comb begin
    mon_master_new  = o_master_delay;
    mon_monitor_new = o_monitor_delay;
    if (i_mon_master_tabs > o_master_delay)       mon_master_new  = o_master_delay + 1'b1;
    else if (i_mon_master_tabs < o_master_delay)  mon_master_new  = o_master_delay - 1'b1;
    if (i_mon_monitor_tabs > o_monitor_delay)      mon_monitor_new = o_monitor_delay + 1'b1;
    else if (i_mon_monitor_tabs < o_monitor_delay) mon_monitor_new = o_monitor_delay - 1'b1;
  end
`else
  // Monitor values pass straight through.
  always_comb begin
    mon_master_new  = i_mon_master_tabs;
    mon_monitor_new = i_mon_monitor_tabs;
  end
`endif

  // Select the winner's tap data and decide whether any targeted tap actually changes.
  always_comb begin
    win_master       = o_master_delay;
    win_monitor      = o_monitor_delay;
    win_sets_monitor = 1'b0;
    case (win)
      GRANT_CAL: win_master = i_cal_master_tabs;
      GRANT_MAN: win_master = i_man_tabs;
      GRANT_MON: begin
        win_master       = mon_master_new;
        win_monitor      = mon_monitor_new;
        win_sets_monitor = 1'b1;
      end
      default: ;
    endcase
    win_equal = (win_master == o_master_delay) &&
                (!win_sets_monitor || (win_monitor == o_monitor_delay));
  end

  // FSM state register.
  always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
    if (!local_clk_200_rst) state <= ST_IDLE;
    else                    state <= state_nxt;
  end

  // Next-state and grant bookkeeping; grants are only taken from IDLE.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    do_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_nxt = win;
        if (win != GRANT_NONE) begin
          state_nxt = win_equal ? ST_ACK : ST_LOAD;
          do_load   = !win_equal;
        end
      end
      ST_LOAD:   state_nxt = (SETTLE_CYCLES == 0) ? ST_ACK : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_ACK;
      ST_ACK: begin
        state_nxt = ST_IDLE;
        grant_nxt = GRANT_NONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output registers double as the latched request data: taps and strobes land with LOAD.
  always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
    if (!local_clk_200_rst) begin
      grant_q         <= GRANT_NONE;
      settle_cnt      <= '0;
      o_master_delay  <= '0;
      o_monitor_delay <= '0;
      o_delay_ld      <= 1'b0;
      o_update_wr     <= 1'b0;
      o_busy          <= 1'b0;
      o_cal_ack       <= 1'b0;
      o_mon_ack       <= 1'b0;
      o_man_ack       <= 1'b0;
    end else begin
      grant_q     <= grant_nxt;
      o_delay_ld  <= do_load;
      o_update_wr <= do_load;
      o_busy      <= (state_nxt != ST_IDLE);
      o_cal_ack   <= (state_nxt == ST_ACK) && (state != ST_ACK) && (grant_nxt == GRANT_CAL);
      o_mon_ack   <= (state_nxt == ST_ACK) && (state != ST_ACK) && (grant_nxt == GRANT_MON);
      o_man_ack   <= (state_nxt == ST_ACK) && (state != ST_ACK) && (grant_nxt == GRANT_MAN);
      if (do_load) begin
        o_master_delay <= win_master;
        if (win_sets_monitor) o_monitor_delay <= win_monitor;
      end
      if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
      else                    settle_cnt <= '0;
    end
  end

  assign o_grant = grant_q;

endmodule
